// File: rtl/label_ram_mp.sv
// rtl/label_ram_mp.sv - multi-port wire-label RAM with write arbitration, deferral and fill flags
// Commit slots 0..P-1 are pending retirements, P..2P-1 are new writes; earlier slots win an address.
module label_ram_mp #(
  parameter int S      = 10,
  parameter int K      = 128,
  parameter int P      = 2,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic [P-1:0]   wr_en,
  input  logic [P*S-1:0] wr_addr,
  input  logic [P*K-1:0] wr_data,
  input  logic [P-1:0]   rd_en,
  input  logic [P*S-1:0] rd_addr,
  output logic [P-1:0]   busy,
  output logic [P-1:0]   rd_valid,
  output logic [P-1:0]   rd_flag,
  output logic [P*K-1:0] rd_data,
  output logic [S:0]     fill_count
);

  localparam int N     = 2 * P;
  localparam int DEPTH = 1 << S;

  logic [K-1:0]       mem [DEPTH];
  logic [DEPTH-1:0]   flag;

  logic [P-1:0]       pend_v;
  logic [S-1:0]       pend_addr [P];
  logic [K-1:0]       pend_data [P];

  logic [N-1:0]       cm_v;
  logic [S-1:0]       cm_addr [N];
  logic [K-1:0]       cm_data [N];
  logic [P-1:0]       defer;
  logic [S:0]         new_fills;
  logic [S+1:0]       fill_sum;
  logic [S:0]         fill_next;

  logic [K-1:0]       fwd_data [P];
  logic [P-1:0]       fwd_flag;

  logic [P-1:0]       v_pipe [RD_LAT];
  logic [P-1:0]       f_pipe [RD_LAT];
  logic [K-1:0]       d_pipe [RD_LAT][P];

  always_comb begin
    logic hit;
    cm_v      = '0;
    defer     = '0;
    new_fills = '0;
    hit       = 1'b0;
    for (int i = 0; i < N; i++) begin
      cm_addr[i] = '0;
      cm_data[i] = '0;
    end
    for (int p = 0; p < P; p++) begin
      hit = 1'b0;
      for (int j = 0; j < p; j++)
        if (cm_v[j] && cm_addr[j] == pend_addr[p]) hit = 1'b1;
      if (!clr && pend_v[p] && !hit) begin
        cm_v[p]    = 1'b1;
        cm_addr[p] = pend_addr[p];
        cm_data[p] = pend_data[p];
      end
    end
    for (int p = 0; p < P; p++) begin
      hit = 1'b0;
      for (int j = 0; j < P + p; j++)
        if (cm_v[j] && cm_addr[j] == wr_addr[p*S +: S]) hit = 1'b1;
      // busy ports drop new requests; clr discards everything presented this cycle
      if (!clr && wr_en[p] && !pend_v[p]) begin
        if (hit) begin
          defer[p] = 1'b1;
        end else begin
          cm_v[P+p]    = 1'b1;
          cm_addr[P+p] = wr_addr[p*S +: S];
          cm_data[P+p] = wr_data[p*K +: K];
        end
      end
    end
    for (int i = 0; i < N; i++)
      new_fills = new_fills + (S+1)'(cm_v[i] && !flag[cm_addr[i]]);
  end

  always_comb begin
    fill_sum  = {1'b0, fill_count} + {1'b0, new_fills};
    fill_next = (fill_sum > (S+2)'(DEPTH)) ? (S+1)'(DEPTH) : fill_sum[S:0];
  end

  // write-first: a commit in the issuing cycle overrides the stored entry
  always_comb begin
    for (int p = 0; p < P; p++) begin
      fwd_data[p] = mem[rd_addr[p*S +: S]];
      fwd_flag[p] = flag[rd_addr[p*S +: S]] && !clr;
      for (int i = 0; i < N; i++) begin
        if (cm_v[i] && cm_addr[i] == rd_addr[p*S +: S]) begin
          fwd_data[p] = cm_data[i];
          fwd_flag[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (cm_v[i]) mem[cm_addr[i]] <= cm_data[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag       <= '0;
      fill_count <= '0;
      pend_v     <= '0;
      for (int p = 0; p < P; p++) begin
        pend_addr[p] <= '0;
        pend_data[p] <= '0;
      end
    end else if (clr) begin
      flag       <= '0;
      fill_count <= '0;
      pend_v     <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (cm_v[i]) flag[cm_addr[i]] <= 1'b1;
      fill_count <= fill_next;
      for (int p = 0; p < P; p++) begin
        if (cm_v[p]) pend_v[p] <= 1'b0;
        if (defer[p]) begin
          pend_v[p]    <= 1'b1;
          pend_addr[p] <= wr_addr[p*S +: S];
          pend_data[p] <= wr_data[p*K +: K];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        v_pipe[s] <= '0;
        f_pipe[s] <= '0;
        for (int p = 0; p < P; p++) d_pipe[s][p] <= '0;
      end
    end else begin
      v_pipe[0] <= rd_en;
      for (int p = 0; p < P; p++) begin
        if (rd_en[p]) begin
          d_pipe[0][p] <= fwd_data[p];
          f_pipe[0][p] <= fwd_flag[p];
        end
      end
      for (int s = 1; s < RD_LAT; s++) begin
        v_pipe[s] <= v_pipe[s-1];
        for (int p = 0; p < P; p++) begin
          if (v_pipe[s-1][p]) begin
            d_pipe[s][p] <= d_pipe[s-1][p];
            f_pipe[s][p] <= f_pipe[s-1][p];
          end
        end
      end
    end
  end

  always_comb begin
    busy     = pend_v;
    rd_valid = v_pipe[RD_LAT-1];
    rd_flag  = f_pipe[RD_LAT-1];
    for (int p = 0; p < P; p++) rd_data[p*K +: K] = d_pipe[RD_LAT-1][p];
  end

endmodule

// File: tb/tb_label_ram_mp.sv
// tb/tb_label_ram_mp.sv - directed scoreboard bench for label_ram_mp, read latency 1 and 2 side by side
module tb_label_ram_mp;

  localparam int S = 4;
  localparam int K = 16;
  localparam int P = 2;

  typedef struct {
    logic [K-1:0] d;
    logic         f;
    int           c;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clr = 1'b0;
  logic [P-1:0]   wr_en = '0;
  logic [P*S-1:0] wr_addr = '0;
  logic [P*K-1:0] wr_data = '0;
  logic [P-1:0]   rd_en = '0;
  logic [P*S-1:0] rd_addr = '0;

  logic [P-1:0]   a_busy, a_rd_valid, a_rd_flag, b_busy, b_rd_valid, b_rd_flag;
  logic [P*K-1:0] a_rd_data, b_rd_data;
  logic [S:0]     a_fill, b_fill;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q [4][$];

  label_ram_mp #(.S(S), .K(K), .P(P), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .busy(a_busy),
    .rd_valid(a_rd_valid), .rd_flag(a_rd_flag), .rd_data(a_rd_data), .fill_count(a_fill)
  );

  label_ram_mp #(.S(S), .K(K), .P(P), .RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .busy(b_busy),
    .rd_valid(b_rd_valid), .rd_flag(b_rd_flag), .rd_data(b_rd_data), .fill_count(b_fill)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    rd_en = '0;
    clr   = 1'b0;
  endtask

  task automatic wr(input int p, input logic [S-1:0] a, input logic [K-1:0] d);
    wr_en[p]         = 1'b1;
    wr_addr[p*S +: S] = a;
    wr_data[p*K +: K] = d;
  endtask

  task automatic rd_raw(input int p, input logic [S-1:0] a);
    rd_en[p]          = 1'b1;
    rd_addr[p*S +: S] = a;
  endtask

  task automatic rd(input int p, input logic [S-1:0] a, input logic [K-1:0] d, input logic f);
    exp_t e;
    rd_raw(p, a);
    e.d = d; e.f = f; e.c = cyc + 1;
    q[p].push_back(e);
    e.c = cyc + 2;
    q[2+p].push_back(e);
  endtask

  task automatic chk_state(input string tag, input logic [1:0] bz, input int fill);
    chk({tag, "_busy_a"}, 32'(a_busy), 32'(bz));
    chk({tag, "_busy_b"}, 32'(b_busy), 32'(bz));
    chk({tag, "_fill_a"}, 32'(a_fill), 32'(fill));
    chk({tag, "_fill_b"}, 32'(b_fill), 32'(fill));
  endtask

  always @(negedge clk) begin
    logic         v;
    logic [K-1:0] d;
    logic         f;
    exp_t         e;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        v = (i >= 2) ? b_rd_valid[i%2] : a_rd_valid[i%2];
        d = (i >= 2) ? b_rd_data[(i%2)*K +: K] : a_rd_data[(i%2)*K +: K];
        f = (i >= 2) ? b_rd_flag[i%2] : a_rd_flag[i%2];
        if (v) begin
          chk($sformatf("rd_expected_q%0d", i), 32'(q[i].size() != 0), 32'd1);
          if (q[i].size() != 0) begin
            e = q[i].pop_front();
            chk($sformatf("rd_data_q%0d", i), 32'(d), 32'(e.d));
            chk($sformatf("rd_flag_q%0d", i), 32'(f), 32'(e.f));
            chk($sformatf("rd_cycle_q%0d", i), 32'(cyc), 32'(e.c));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("reset_valid_a", 32'(a_rd_valid), 32'd0);
    chk("reset_valid_b", 32'(b_rd_valid), 32'd0);
    chk("reset_data_a", a_rd_data, 32'd0);
    chk("reset_flag_b", 32'(b_rd_flag), 32'd0);
    chk_state("reset", 2'b00, 0);
    rst_n = 1'b1;
    step();

    wr(0, 5, 16'h00A5);
    step();
    idle();
    rd(0, 5, 16'h00A5, 1'b1);
    step();
    idle();
    chk_state("t1", 2'b00, 1);

    wr(0, 7, 16'h0011);
    wr(1, 7, 16'h0022);
    step();
    idle();
    chk_state("t2_defer", 2'b10, 2);
    wr(1, 8, 16'h0033);
    step();
    idle();
    chk_state("t2_retire", 2'b00, 2);
    rd(0, 7, 16'h0022, 1'b1);
    step();
    idle();

    wr(0, 3, 16'hBEEF);
    rd(1, 3, 16'hBEEF, 1'b1);
    step();
    idle();
    chk_state("t3", 2'b00, 3);

    wr(0, 1, 16'h0101);
    wr(1, 2, 16'h0202);
    step();
    idle();
    rd(0, 1, 16'h0101, 1'b1);
    step();
    rd(0, 2, 16'h0202, 1'b1);
    step();
    rd(0, 3, 16'hBEEF, 1'b1);
    step();
    idle();
    step();
    chk_state("t4", 2'b00, 5);

    wr(0, 9, 16'h0099);
    wr(1, 10, 16'h1010);
    step();
    idle();
    wr(0, 11, 16'h1111);
    wr(1, 5, 16'h0055);
    step();
    idle();
    chk_state("t5_fill", 2'b00, 8);
    wr(0, 12, 16'h0001);
    wr(1, 12, 16'h0002);
    step();
    idle();
    chk_state("t5_pend", 2'b10, 9);
    clr = 1'b1;
    wr(0, 9, 16'h0077);
    rd(1, 5, 16'h0055, 1'b0);
    step();
    idle();
    chk_state("t5_clr", 2'b00, 0);
    rd(0, 9, 16'h0099, 1'b0);
    rd(1, 12, 16'h0001, 1'b0);
    step();
    idle();
    step();
    step();
    chk_state("t5_after", 2'b00, 0);

    wr(0, 13, 16'h0005);
    wr(1, 13, 16'h0006);
    rd_raw(1, 3);
    step();
    idle();
    chk_state("t6_pre", 2'b10, 1);
    chk("t6_pre_valid_a", 32'(a_rd_valid), 32'h2);
    rst_n = 1'b0;
    #1;
    chk_state("t6_rst", 2'b00, 0);
    chk("t6_rst_valid_a", 32'(a_rd_valid), 32'd0);
    chk("t6_rst_valid_b", 32'(b_rd_valid), 32'd0);
    chk("t6_rst_data_a", a_rd_data, 32'd0);
    chk("t6_rst_data_b", b_rd_data, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk_state("t6_after", 2'b00, 0);
    rd(0, 13, 16'h0005, 1'b0);
    step();
    idle();
    step();
    step();
    step();

    chk("queues_drained", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
